// File: rtl/lvds_trigger_engine.sv
// Pre-trigger ring buffer plus hysteresis/auto/force trigger FSM feeding the sample write FIFO.
// Trigger word T reaches fifo_wr 3 cycles after it is on lvds_bits; FIFO high-water stops capture (no stall).
module lvds_trigger_engine #(
    parameter int NSAMP    = 10,
    parameter int SAMPW    = 12,
    parameter int TRIGLANE = 0,
    parameter int DEPTH    = 256,
    parameter int FIFO_AW  = 11,
    parameter int HIWATER  = 1020
) (
    input  logic                       clklvds,
    input  logic                       rstn,
    input  logic [NSAMP*SAMPW-1:0]     lvds_bits,
    input  logic                       arm,
    input  logic                       force_trig,
    input  logic [1:0]                 mode,
    input  logic signed [SAMPW-1:0]    lower_thresh,
    input  logic signed [SAMPW-1:0]    upper_thresh,
    input  logic [$clog2(DEPTH)-1:0]   pretrig,
    input  logic [15:0]                length,
    input  logic [15:0]                auto_timeout,
    output logic                       fifo_wr,
    output logic [NSAMP*SAMPW-1:0]     fifo_data,
    input  logic [FIFO_AW-1:0]         fifo_wrused,
    output logic                       busy,
    output logic                       done,
    output logic                       overrun,
    output logic                       auto_trig,
    output logic [15:0]                word_count
);
    localparam int AW = $clog2(DEPTH);
    localparam int WW = NSAMP * SAMPW;
    localparam logic [FIFO_AW-1:0] HIWATER_LVL = FIFO_AW'(HIWATER);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_FILL  = 3'd1;
    localparam logic [2:0] ST_ARM_A = 3'd2;
    localparam logic [2:0] ST_ARM_B = 3'd3;
    localparam logic [2:0] ST_CAPT  = 3'd4;
    localparam logic [2:0] ST_DONE  = 3'd5;

    logic [2:0]              state_q, state_d;
    logic                    arm_s1_q, arm_s1_d, arm_s2_q, arm_s2_d;
    logic                    frc_s1_q, frc_s1_d, frc_s2_q, frc_s2_d, frc_s3_q, frc_s3_d;
    logic [AW-1:0]           wptr_q, wptr_d;
    logic signed [SAMPW-1:0] samp_q, samp_d;
    logic [1:0]              mode_q, mode_d;
    logic signed [SAMPW-1:0] lo_q, lo_d, up_q, up_d;
    logic [AW-1:0]           pretrig_q, pretrig_d;
    logic [15:0]             length_q, length_d;
    logic [15:0]             auto_to_q, auto_to_d;
    logic [AW-1:0]           fill_cnt_q, fill_cnt_d;
    logic [15:0]             auto_cnt_q, auto_cnt_d;
    logic [15:0]             word_count_q, word_count_d;
    logic                    overrun_q, overrun_d;
    logic                    auto_trig_q, auto_trig_d;
    logic                    fifo_wr_q, fifo_wr_d;
    logic [WW-1:0]           fifo_data_q, fifo_data_d;

    logic [WW-1:0]           ring [DEPTH];
    logic [WW-1:0]           ring_rd_q;
    logic [AW-1:0]           rd_addr;
    logic                    below_lo, above_up, thr_arm, thr_trig, auto_hit, frc_rise, trig;

    // Extra -1: the word written this edge is read back one cycle later, so
    // ring_rd_q already trails the input by pretrig+1 and the output register adds the last stage.
    always_ff @(posedge clklvds) begin
        ring[wptr_q] <= lvds_bits;
        ring_rd_q    <= ring[rd_addr];
    end

    always_comb begin
        rd_addr  = wptr_q - pretrig_q - AW'(1);
        below_lo = samp_q < lo_q;
        above_up = samp_q > up_q;
        thr_arm  = (mode_q == 2'd1) ? above_up : below_lo;
        thr_trig = (mode_q == 2'd1) ? below_lo : above_up;
        auto_hit = (mode_q == 2'd2) && (auto_cnt_q >= auto_to_q);
        frc_rise = frc_s2_q & ~frc_s3_q;
        trig     = 1'b0;

        state_d      = state_q;
        arm_s1_d     = arm;
        arm_s2_d     = arm_s1_q;
        frc_s1_d     = force_trig;
        frc_s2_d     = frc_s1_q;
        frc_s3_d     = frc_s2_q;
        wptr_d       = wptr_q + AW'(1);
        samp_d       = lvds_bits[TRIGLANE*SAMPW +: SAMPW];
        mode_d       = mode_q;
        lo_d         = lo_q;
        up_d         = up_q;
        pretrig_d    = pretrig_q;
        length_d     = length_q;
        auto_to_d    = auto_to_q;
        fill_cnt_d   = fill_cnt_q;
        auto_cnt_d   = auto_cnt_q;
        word_count_d = word_count_q;
        overrun_d    = overrun_q;
        auto_trig_d  = auto_trig_q;
        fifo_wr_d    = 1'b0;
        fifo_data_d  = fifo_data_q;

        // Dropping arm wins over everything, so a capture never writes after abort is seen.
        if (!arm_s2_q) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    mode_d       = mode;
                    lo_d         = lower_thresh;
                    up_d         = upper_thresh;
                    pretrig_d    = pretrig;
                    length_d     = length;
                    auto_to_d    = auto_timeout;
                    fill_cnt_d   = '0;
                    auto_cnt_d   = '0;
                    word_count_d = '0;
                    overrun_d    = 1'b0;
                    auto_trig_d  = 1'b0;
                    state_d      = ST_FILL;
                end
                ST_FILL: begin
                    if (fill_cnt_q == pretrig_q) state_d = ST_ARM_A;
                    else fill_cnt_d = fill_cnt_q + AW'(1);
                end
                ST_ARM_A, ST_ARM_B: begin
                    if (mode_q == 2'd2 && auto_cnt_q != 16'hFFFF) auto_cnt_d = auto_cnt_q + 16'd1;
                    if (state_q == ST_ARM_A) begin
                        if (mode_q == 2'd3) trig = 1'b1;
                        else if (thr_arm) state_d = ST_ARM_B;
                    end else begin
                        trig = thr_trig;
                    end
                    // Threshold or force takes precedence, so auto_trig only flags a pure timeout.
                    if (trig || frc_rise) begin
                        state_d = ST_CAPT;
                    end else if (auto_hit) begin
                        state_d     = ST_CAPT;
                        auto_trig_d = 1'b1;
                    end
                end
                ST_CAPT: begin
                    if (word_count_q >= length_q) begin
                        state_d = ST_DONE;
                    end else if (fifo_wrused >= HIWATER_LVL) begin
                        overrun_d = 1'b1;
                        state_d   = ST_DONE;
                    end else begin
                        fifo_wr_d    = 1'b1;
                        fifo_data_d  = ring_rd_q;
                        word_count_d = word_count_q + 16'd1;
                        if (word_count_q + 16'd1 == length_q) state_d = ST_DONE;
                    end
                end
                ST_DONE: state_d = ST_DONE;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clklvds or negedge rstn) begin
        if (!rstn) begin
            state_q      <= ST_IDLE;
            arm_s1_q     <= 1'b0;
            arm_s2_q     <= 1'b0;
            frc_s1_q     <= 1'b0;
            frc_s2_q     <= 1'b0;
            frc_s3_q     <= 1'b0;
            wptr_q       <= '0;
            samp_q       <= '0;
            mode_q       <= '0;
            lo_q         <= '0;
            up_q         <= '0;
            pretrig_q    <= '0;
            length_q     <= '0;
            auto_to_q    <= '0;
            fill_cnt_q   <= '0;
            auto_cnt_q   <= '0;
            word_count_q <= '0;
            overrun_q    <= 1'b0;
            auto_trig_q  <= 1'b0;
            fifo_wr_q    <= 1'b0;
            fifo_data_q  <= '0;
        end else begin
            state_q      <= state_d;
            arm_s1_q     <= arm_s1_d;
            arm_s2_q     <= arm_s2_d;
            frc_s1_q     <= frc_s1_d;
            frc_s2_q     <= frc_s2_d;
            frc_s3_q     <= frc_s3_d;
            wptr_q       <= wptr_d;
            samp_q       <= samp_d;
            mode_q       <= mode_d;
            lo_q         <= lo_d;
            up_q         <= up_d;
            pretrig_q    <= pretrig_d;
            length_q     <= length_d;
            auto_to_q    <= auto_to_d;
            fill_cnt_q   <= fill_cnt_d;
            auto_cnt_q   <= auto_cnt_d;
            word_count_q <= word_count_d;
            overrun_q    <= overrun_d;
            auto_trig_q  <= auto_trig_d;
            fifo_wr_q    <= fifo_wr_d;
            fifo_data_q  <= fifo_data_d;
        end
    end

    assign fifo_wr    = fifo_wr_q;
    assign fifo_data  = fifo_data_q;
    assign busy       = (state_q == ST_FILL) || (state_q == ST_ARM_A) ||
                        (state_q == ST_ARM_B) || (state_q == ST_CAPT);
    assign done       = (state_q == ST_DONE);
    assign overrun    = overrun_q;
    assign auto_trig  = auto_trig_q;
    assign word_count = word_count_q;

endmodule
